reg_dump_reader: RTL

Debug readout engine for the MIPS register file. On a start pulse it walks the register file read port from register 0 to NUM_REGS-1, registers each value, and streams (index, value) pairs out over a valid/ready handshake. It sits beside the datapath on a spare register-file read port. It feeds the testbench monitor or a debug UART, and never writes the register file.

---
 rtl/reg_dump_reader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: debug readout engine for the MIPS register file.
// On a start pulse it walks the spare register-file read port from index 0
// to NUM_REGS-1. It captures each value and streams (index, value) pairs out
// over a valid/ready handshake. It never writes the register file.
//
// Optional feature: define REG_DUMP_SKIP_ZERO_EN to drop registers that read
// zero. Register 0 is then always skipped. The default build emits every
// register.
module reg_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   dump_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_READ    = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              busy_q, valid_q, done_q;
    logic              handshake;
    logic              skip_entry;

    assign handshake = valid_q & out_ready;

`ifdef REG_DUMP_SKIP_ZERO_EN
    // A zero register produces no entry. Register 0 always reads zero, so
    // it is always skipped.
    assign skip_entry = (rd_data == '0);
`else
    assign skip_entry = 1'b0;
`endif

    // Next-state and datapath update for the walk.
    always_comb begin
        // NOTE: every _d takes its _q value first, so paths that assign
        // nothing hold state instead of inferring a latch.
        state_d     = state_q;
        index_d     = index_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        count_d     = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    index_d = '0;
                    count_d = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (skip_entry) begin
                    if (index_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end else begin
                    // The value before this edge is the snapshot. A
                    // same-edge register-file write is not seen here.
                    out_data_d  = rd_data;
                    out_index_d = index_q;
                    state_d     = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (handshake) begin
                    count_d = count_q + 1'b1;
                    if (index_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                // Return the read address to 0 for IDLE.
                index_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers. busy, out_valid and done are registered decodes of
    // the next state, so they match the current state without glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            out_index_q <= '0;
            out_data_q  <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments ensure every flop samples
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            index_q     <= index_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            count_q     <= count_d;
            busy_q      <= (state_d == S_READ) || (state_d == S_PRESENT);
            valid_q     <= (state_d == S_PRESENT);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign out_valid  = valid_q;
    assign rd_addr    = index_q;
    assign out_index  = out_index_q;
    assign out_data   = out_data_q;
    assign dump_count = count_q;

endmodule
